fc_relu_layer: RTL and testbench
================================

Name: fc_relu_layer

Overview:
- Fully-connected layer that consumes the 50 pooled conv2 activations (400-bit vector plus finish level) and produces OUT_NUM 8-bit neuron outputs.
- Reads one weights+bias row per neuron from the FC weight SRAM, which has 2-cycle read latency.
- Accumulates the row with LANES multipliers per cycle, then applies bias, ReLU and saturation.
- Sits directly downstream of the conv2/pool stage and upstream of the classifier or next FC layer.

Parameters:
- IN_NUM, 50, number of input activations; IN_NUM % LANES must be 0.
- OUT_NUM, 10, number of output neurons.
- LANES, 5, multiply lanes per MAC cycle.
- ADDR_W, 11, weight SRAM address width.
- WB_BASE, 0, SRAM address of neuron 0's row.
- BIAS_SHIFT, 5, left shift applied to bias magnitude.
- OUT_SHIFT, 5, right shift applied to the accumulator before output.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fc_en  in  1  start level; a rising edge starts a pass.
- act_in  in  IN_NUM*8  activation i at [8i+7:8i], unsigned.
- fc_wb  in  IN_NUM*8+8  SRAM row: bias at [7:0], weight i at [8i+15:8i+8].
- fc_wb_sram_addra  out  ADDR_W  SRAM address.
- fc_wb_sram_ena  out  1  SRAM enable.
- fc_busy  out  1  pass in progress.
- fc_done  out  1  one-cycle completion pulse.
- fc_res  out  OUT_NUM*8  neuron k at [8k+7:8k].

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset mid-pass aborts immediately; fc_res clears to 0.
- Number format:
  - Weights and bias are 8-bit sign-magnitude: bit7 = sign, [6:0] = magnitude. Negative zero is treated as 0.
  - Accumulator is 24-bit two's complement and cannot overflow (max |sum| 1,619,250 plus bias).
- Start condition: fc_en_d is a registered copy of fc_en. A pass starts in IDLE when fc_en & ~fc_en_d.
  - A level held high after a pass does not restart.
  - fc_en edges while busy are ignored.
- IDLE: on start, latch act_in into act_reg, set neuron=0, fc_busy<=1, go to LOAD. act_in may change after the start edge.
- LOAD (3 cycles):
  - Cycle 0: ena<=1, addra<=WB_BASE+neuron.
  - Cycle 2: capture fc_wb into w_reg; acc <= +/-(bias_mag<<BIAS_SHIFT); ena<=0; go to MAC.
- MAC (IN_NUM/LANES cycles): group g adds the signed products act[g*LANES+j]*w[g*LANES+j] for j=0..LANES-1 to acc. Go to ACT after the last group.
- ACT (1 cycle):
  - out = 0 if acc<0; else min(acc>>OUT_SHIFT, 255).
  - Write out to fc_res slot neuron. Other slots hold their values.
  - If neuron==OUT_NUM-1: fc_done<=1, fc_busy<=0, go to IDLE. Else neuron++, go to LOAD.
- fc_done is high for exactly one cycle. fc_res is stable from fc_done until the next start.
- Latency: let E0 be the clock edge at which the rising fc_en is sampled.
  - Each neuron takes 3+IN_NUM/LANES+1 = 14 cycles.
  - The last ACT occurs at edge E0+OUT_NUM*14 (E140 with defaults); fc_done is high in the following cycle.
- fc_wb_sram_ena is high only during LOAD cycles 0-1. Exactly one SRAM read is issued per neuron.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: ReLU/unsigned output as described under ACT.
- Undefined (raw-logit layer): out = arithmetic acc>>>OUT_SHIFT (floor), clamped to -128..127, stored as two's complement.

Test Plan:
- act all 8'd4, weights all 8'h01, bias 8'h00 -> acc=200; every fc_res byte = 8'd6.
- act all 8'd4, weights all 8'h81, bias 0 -> with FC_RELU_EN every byte 8'h00; without it every byte 8'hF9 (-7).
- act all 8'd255, weights all 8'h7F, bias 8'h7F -> saturation; every byte 8'hFF with FC_RELU_EN, 8'h7F without.
- Weights 0, neuron k bias = 8'h03 for even k and 8'h83 for odd k -> even bytes 8'd3; odd bytes 0 (FC_RELU_EN) or 8'hFD (without).
- fc_en rises and is held high for 400 cycles:
  - fc_busy rises after E0; exactly 10 SRAM reads occur at addresses WB_BASE..WB_BASE+9.
  - fc_done pulses once, in the cycle after E140; no second pass starts.
  - act_in changed after E0 does not alter results.
- rst pulsed during neuron 4's MAC -> all outputs 0 immediately, state IDLE. A later fc_en rising edge then completes a full, correct pass.

Source files
------------

// File: rtl/fc_relu_layer.sv
// fc_relu_layer: fully-connected layer over the pooled conv2 activations, one SRAM row per neuron.
// Define FC_RELU_EN for ReLU/unsigned outputs; left undefined the layer emits clamped signed logits.
module fc_relu_layer #(
   parameter int IN_NUM     = 50,
   parameter int OUT_NUM    = 10,
   parameter int LANES      = 5,
   parameter int ADDR_W     = 11,
   parameter int WB_BASE    = 0,
   parameter int BIAS_SHIFT = 5,
   parameter int OUT_SHIFT  = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fc_en,
   input  logic [IN_NUM*8-1:0]     act_in,
   input  logic [IN_NUM*8+7:0]     fc_wb,
   output logic [ADDR_W-1:0]       fc_wb_sram_addra,
   output logic                    fc_wb_sram_ena,
   output logic                    fc_busy,
   output logic                    fc_done,
   output logic [OUT_NUM*8-1:0]    fc_res
);

   localparam int GROUPS = IN_NUM / LANES;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int NW     = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_MAC  = 2'd2;
   localparam logic [1:0] S_ACT  = 2'd3;

   logic [1:0]           state;
   logic                 fc_en_d;
   logic [IN_NUM*8-1:0]  act_reg;
   logic [IN_NUM*8-1:0]  w_reg;
   logic signed [23:0]   acc;
   logic [1:0]           load_cnt;
   logic [GW-1:0]        grp;
   logic [NW-1:0]        neuron;
   logic signed [23:0]   mac_sum;
   logic signed [23:0]   bias_val;
   logic [7:0]           out_byte;
   logic                 start;

   assign start = fc_en & ~fc_en_d;

   // Sign-magnitude bias, pre-scaled so it lines up with the product sum.
   always_comb begin
      logic [23:0] bias_mag;
      bias_mag = {17'd0, fc_wb[6:0]} << BIAS_SHIFT;
      bias_val = fc_wb[7] ? $signed(24'd0 - bias_mag) : $signed(bias_mag);
   end

   always_comb begin
      logic [7:0]  a_b;
      logic [7:0]  w_b;
      logic [14:0] p;
      logic [23:0] term;
      int          base;
      mac_sum = '0;
      a_b     = '0;
      w_b     = '0;
      p       = '0;
      term    = '0;
      base    = int'(grp) * LANES;
      for (int j = 0; j < LANES; j++) begin
         a_b     = act_reg[(base + j)*8 +: 8];
         w_b     = w_reg[(base + j)*8 +: 8];
         p       = a_b * w_b[6:0];
         term    = w_b[7] ? (24'd0 - {9'd0, p}) : {9'd0, p};
         mac_sum = mac_sum + $signed(term);
      end
   end

   always_comb begin
      logic signed [23:0] q;
      q        = acc >>> OUT_SHIFT;
      out_byte = '0;
`ifdef FC_RELU_EN
      if (acc[23])
         out_byte = 8'h00;
      else if (q > 24'sd255)
         out_byte = 8'hFF;
      else
         out_byte = q[7:0];
`else
      if (q > 24'sd127)
         out_byte = 8'h7F;
      else if (q < -24'sd128)
         out_byte = 8'h80;
      else
         out_byte = q[7:0];
`endif
   end

   // The SRAM address and enable are issued on entry to LOAD so the row arrives by its third cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_IDLE;
         fc_en_d          <= 1'b0;
         act_reg          <= '0;
         w_reg            <= '0;
         acc              <= '0;
         load_cnt         <= '0;
         grp              <= '0;
         neuron           <= '0;
         fc_wb_sram_addra <= '0;
         fc_wb_sram_ena   <= 1'b0;
         fc_busy          <= 1'b0;
         fc_done          <= 1'b0;
         fc_res           <= '0;
      end else begin
         fc_en_d <= fc_en;
         fc_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  act_reg          <= act_in;
                  neuron           <= '0;
                  fc_busy          <= 1'b1;
                  load_cnt         <= '0;
                  fc_wb_sram_ena   <= 1'b1;
                  fc_wb_sram_addra <= ADDR_W'(WB_BASE);
                  state            <= S_LOAD;
               end
            end
            S_LOAD: begin
               load_cnt <= load_cnt + 2'd1;
               if (load_cnt == 2'd1)
                  fc_wb_sram_ena <= 1'b0;
               if (load_cnt == 2'd2) begin
                  w_reg <= fc_wb[IN_NUM*8+7:8];
                  acc   <= bias_val;
                  grp   <= '0;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + mac_sum;
               if (grp == GW'(GROUPS - 1))
                  state <= S_ACT;
               else
                  grp <= grp + 1'b1;
            end
            S_ACT: begin
               fc_res[int'(neuron)*8 +: 8] <= out_byte;
               if (neuron == NW'(OUT_NUM - 1)) begin
                  fc_done <= 1'b1;
                  fc_busy <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  neuron           <= neuron + 1'b1;
                  load_cnt         <= '0;
                  fc_wb_sram_ena   <= 1'b1;
                  fc_wb_sram_addra <= ADDR_W'(WB_BASE + int'(neuron) + 1);
                  state            <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_relu_layer.sv
// Self-checking bench for fc_relu_layer: integer reference model plus a 2-cycle-latency SRAM model.
// Build with or without FC_RELU_EN; the model follows the same macro.
module tb_fc_relu_layer;

   localparam int IN_NUM  = 50;
   localparam int OUT_NUM = 10;
   localparam int ADDR_W  = 11;
   localparam int WB_BASE = 0;
   localparam int SCALE   = 32;

   logic                     clk;
   logic                     rst;
   logic                     fc_en;
   logic [IN_NUM*8-1:0]      act_in;
   logic [IN_NUM*8+7:0]      fc_wb;
   logic [ADDR_W-1:0]        fc_wb_sram_addra;
   logic                     fc_wb_sram_ena;
   logic                     fc_busy;
   logic                     fc_done;
   logic [OUT_NUM*8-1:0]     fc_res;

   logic [IN_NUM*8+7:0]      mem [0:OUT_NUM-1];
   logic [IN_NUM*8+7:0]      s1;
   logic [IN_NUM*8+7:0]      s2;

   int act_m [IN_NUM];
   int wb_m  [OUT_NUM][IN_NUM+1];
   int errors;
   int checks;

   fc_relu_layer dut (
      .clk              (clk),
      .rst              (rst),
      .fc_en            (fc_en),
      .act_in           (act_in),
      .fc_wb            (fc_wb),
      .fc_wb_sram_addra (fc_wb_sram_addra),
      .fc_wb_sram_ena   (fc_wb_sram_ena),
      .fc_busy          (fc_busy),
      .fc_done          (fc_done),
      .fc_res           (fc_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-stage read pipeline stands in for the weight SRAM.
   always @(posedge clk) begin
      if (fc_wb_sram_ena) begin
         if (fc_wb_sram_addra < ADDR_W'(OUT_NUM))
            s1 <= mem[fc_wb_sram_addra[3:0]];
         else
            s1 <= '0;
      end
      s2 <= s1;
   end
   assign fc_wb = s2;

   function automatic int sm(input int b);
      if (((b >> 7) & 1) == 1)
         return -(b & 127);
      return b & 127;
   endfunction

   function automatic logic [7:0] expect_byte(input int k);
      int sum;
      int q;
      sum = sm(wb_m[k][0]) * SCALE;
      for (int i = 0; i < IN_NUM; i++)
         sum += act_m[i] * sm(wb_m[k][i+1]);
`ifdef FC_RELU_EN
      if (sum < 0)
         return 8'h00;
      q = sum / SCALE;
      if (q > 255)
         return 8'hFF;
      return 8'(q);
`else
      if (sum >= 0)
         q = sum / SCALE;
      else
         q = -((-sum + SCALE - 1) / SCALE);
      if (q > 127)
         q = 127;
      if (q < -128)
         q = -128;
      return 8'(q);
`endif
   endfunction

   task automatic apply_memory();
      for (int k = 0; k < OUT_NUM; k++) begin
         mem[k][7:0] = 8'(wb_m[k][0]);
         for (int i = 0; i < IN_NUM; i++)
            mem[k][i*8+8 +: 8] = 8'(wb_m[k][i+1]);
      end
      for (int i = 0; i < IN_NUM; i++)
         act_in[i*8 +: 8] = 8'(act_m[i]);
   endtask

   task automatic set_uniform(input int a, input int w, input int b, input bit alt);
      for (int i = 0; i < IN_NUM; i++)
         act_m[i] = a;
      for (int k = 0; k < OUT_NUM; k++) begin
         wb_m[k][0] = (alt && (k % 2 == 1)) ? (b | 128) : b;
         for (int i = 0; i < IN_NUM; i++)
            wb_m[k][i+1] = w;
      end
      apply_memory();
   endtask

   task automatic set_random();
      for (int i = 0; i < IN_NUM; i++)
         act_m[i] = int'($urandom_range(0, 63));
      for (int k = 0; k < OUT_NUM; k++) begin
         wb_m[k][0] = int'($urandom_range(0, 255));
         for (int i = 0; i < IN_NUM; i++)
            wb_m[k][i+1] = int'($urandom_range(0, 7)) | (int'($urandom_range(0, 1)) << 7);
      end
      apply_memory();
   endtask

   // Drives one clean fc_en rising edge and waits (bounded) for fc_done.
   task automatic run_pass(output bit finished);
      int cyc;
      @(negedge clk);
      fc_en = 1'b0;
      repeat (2) @(negedge clk);
      fc_en = 1'b1;
      cyc = 0;
      while (fc_done !== 1'b1 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      finished = (fc_done === 1'b1);
      fc_en = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      fc_en = 1'b0;
      act_in = '0;
      #1;
      checks++;
      if (fc_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b want 0", fc_busy); end
      checks++;
      if (fc_done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b want 0", fc_done); end
      checks++;
      if (fc_wb_sram_ena !== 1'b0) begin errors++; $display("[TB] FAIL reset ena: got %b want 0", fc_wb_sram_ena); end
      checks++;
      if (fc_wb_sram_addra !== '0) begin errors++; $display("[TB] FAIL reset addra: got %h want 0", fc_wb_sram_addra); end
      checks++;
      if (fc_res !== '0) begin errors++; $display("[TB] FAIL reset res: got %h want 0", fc_res); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_uniform_patterns();
      int  ta [4] = '{4, 4, 255, 0};
      int  tw [4] = '{8'h01, 8'h81, 8'h7F, 8'h00};
      int  tb [4] = '{8'h00, 8'h00, 8'h7F, 8'h03};
      bit  alt[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      bit  finished;
      logic [7:0] want;
      for (int t = 0; t < 4; t++) begin
         set_uniform(ta[t], tw[t], tb[t], alt[t]);
         run_pass(finished);
         checks++;
         if (!finished) begin errors++; $display("[TB] FAIL uniform%0d timeout: done=%b want 1", t, fc_done); end
         for (int k = 0; k < OUT_NUM; k++) begin
            want = expect_byte(k);
            checks++;
            if (fc_res[k*8 +: 8] !== want) begin
               errors++;
               $display("[TB] FAIL uniform%0d byte%0d: got %h want %h", t, k, fc_res[k*8 +: 8], want);
            end
         end
      end
   endtask

   task automatic test_random();
      bit finished;
      logic [7:0] want;
      for (int t = 0; t < 3; t++) begin
         set_random();
         run_pass(finished);
         checks++;
         if (!finished) begin errors++; $display("[TB] FAIL random%0d timeout: done=%b want 1", t, fc_done); end
         for (int k = 0; k < OUT_NUM; k++) begin
            want = expect_byte(k);
            checks++;
            if (fc_res[k*8 +: 8] !== want) begin
               errors++;
               $display("[TB] FAIL random%0d byte%0d: got %h want %h", t, k, fc_res[k*8 +: 8], want);
            end
         end
      end
   endtask

   // fc_en held high for 400 cycles: one pass, ten reads, one done pulse at E140.
   task automatic test_held_level();
      int   reads;
      int   done_cnt;
      int   done_at;
      logic ena_prev;
      logic [ADDR_W-1:0] addrs[$];
      logic [7:0] want;
      set_random();
      @(negedge clk);
      fc_en = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (fc_busy !== 1'b0) begin errors++; $display("[TB] FAIL held pre-busy: got %b want 0", fc_busy); end
      fc_en    = 1'b1;
      reads    = 0;
      done_cnt = 0;
      done_at  = -1;
      ena_prev = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (fc_busy !== 1'b1) begin errors++; $display("[TB] FAIL held busy-after-E0: got %b want 1", fc_busy); end
         end
         if (c == 2)
            for (int i = 0; i < IN_NUM; i++)
               act_in[i*8 +: 8] = 8'($urandom);
         if (fc_wb_sram_ena === 1'b1 && ena_prev !== 1'b1) begin
            reads++;
            addrs.push_back(fc_wb_sram_addra);
         end
         ena_prev = fc_wb_sram_ena;
         if (fc_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0)
               done_at = c;
         end
      end
      checks++;
      if (reads != OUT_NUM) begin errors++; $display("[TB] FAIL held reads: got %0d want %0d", reads, OUT_NUM); end
      for (int i = 0; i < addrs.size() && i < OUT_NUM; i++) begin
         checks++;
         if (addrs[i] !== ADDR_W'(WB_BASE + i)) begin
            errors++;
            $display("[TB] FAIL held addr%0d: got %0d want %0d", i, addrs[i], WB_BASE + i);
         end
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("[TB] FAIL held done-count: got %0d want 1", done_cnt); end
      checks++;
      if (done_at != OUT_NUM * 14) begin errors++; $display("[TB] FAIL held done-cycle: got %0d want %0d", done_at, OUT_NUM * 14); end
      checks++;
      if (fc_busy !== 1'b0) begin errors++; $display("[TB] FAIL held restart-busy: got %b want 0", fc_busy); end
      for (int k = 0; k < OUT_NUM; k++) begin
         want = expect_byte(k);
         checks++;
         if (fc_res[k*8 +: 8] !== want) begin
            errors++;
            $display("[TB] FAIL held byte%0d: got %h want %h", k, fc_res[k*8 +: 8], want);
         end
      end
      fc_en = 1'b0;
   endtask

   // Reset lands in neuron 4's MAC phase, then a fresh edge must complete a clean pass.
   task automatic test_reset_mid_pass();
      bit finished;
      logic [7:0] want;
      set_uniform(4, 8'h01, 8'h00, 1'b0);
      @(negedge clk);
      fc_en = 1'b0;
      repeat (2) @(negedge clk);
      fc_en = 1'b1;
      for (int c = 0; c < 64; c++)
         @(negedge clk);
      checks++;
      if (fc_busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst busy-before: got %b want 1", fc_busy); end
      rst   = 1'b1;
      fc_en = 1'b0;
      #1;
      checks++;
      if (fc_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst busy: got %b want 0", fc_busy); end
      checks++;
      if (fc_wb_sram_ena !== 1'b0) begin errors++; $display("[TB] FAIL midrst ena: got %b want 0", fc_wb_sram_ena); end
      checks++;
      if (fc_wb_sram_addra !== '0) begin errors++; $display("[TB] FAIL midrst addra: got %h want 0", fc_wb_sram_addra); end
      checks++;
      if (fc_res !== '0) begin errors++; $display("[TB] FAIL midrst res: got %h want 0", fc_res); end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (fc_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst idle: got %b want 0", fc_busy); end
      set_random();
      run_pass(finished);
      checks++;
      if (!finished) begin errors++; $display("[TB] FAIL midrst timeout: done=%b want 1", fc_done); end
      for (int k = 0; k < OUT_NUM; k++) begin
         want = expect_byte(k);
         checks++;
         if (fc_res[k*8 +: 8] !== want) begin
            errors++;
            $display("[TB] FAIL midrst byte%0d: got %h want %h", k, fc_res[k*8 +: 8], want);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_uniform_patterns();
      test_random();
      test_held_level();
      test_reset_mid_pass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
